val2_generator_seq: RTL and testbench
=====================================

Name: val2_generator_seq

Overview:
- Sequential, parametrised successor to the combinational operand-2 generator in the ARM EXE stage.
- Produces val2 and the shifter carry-out for data-processing and memory instructions: immediate rotate, immediate-amount shift, and register-amount (Rs) shift.
- Register/immediate-amount shifts are performed iteratively, STEP bits per cycle, behind valid/ready handshakes.
- Lets the EXE stage stall on long shifts instead of carrying a full-width barrel shifter.

Parameters:
WIDTH, 32, datapath width; power of 2, 32 or 64.
STEP, 1, max bits shifted per SHIFT cycle; power of 2, 1..WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request (high only in IDLE).
Rm  input  WIDTH  operand to shift.
Rs  input  WIDTH  register shift amount; only Rs[7:0] is used.
shift_operand  input  12  instruction bits [11:0].
immd  input  1  I bit.
is_mem_command  input  1  memory instruction; val2 = zero-extended offset.
carry_in  input  1  current C flag.
out_valid  output  1  result valid.
out_ready  input  1  consumer takes result.
val2_out  output  WIDTH  operand-2 result.
carry_out  output  1  shifter carry-out.

Behaviour:
- Clock/reset: one clock `clk`. Reset is asynchronous, active-low, port `rst_n`.
- State reset values: state=IDLE, val2_out=0, carry_out=0, out_valid=0. in_ready=1 (in_ready is decoded from state==IDLE).
- Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, SHIFT, DONE.
  - out_valid = (state==DONE).
  - Accept happens on in_valid && in_ready.
  - Inputs are ignored when in_ready is low.
- Load cycle (accept edge) latches the working value, shift type, remaining count cnt, and carry, then goes to SHIFT if cnt>0, else DONE.
- Load rules:
  - is_mem_command=1 (highest priority): val = {0, shift_operand}; carry = carry_in; cnt = 0.
  - immd=1: val = {0, imm8} ROR (2*rot4), computed in the load cycle. carry = (rot4==0) ? carry_in : val[WIDTH-1]. cnt = 0.
  - immd=0, bit4=0 (immediate amount a = bits[11:7]; type = bits[6:5]: LSL=00, LSR=01, ASR=10, ROR=11):
    - LSL #0: val = Rm, carry = carry_in, cnt = 0.
    - LSR #0 / ASR #0 encode a shift of 32.
    - ROR #0 is RRX: val = {carry_in, Rm[WIDTH-1:1]}, carry = Rm[0], cnt = 0.
  - immd=0, bit4=1 (a = Rs[7:0]):
    - a==0: val = Rm, carry = carry_in, cnt = 0.
    - ROR with a%WIDTH==0 and a!=0: val = Rm, carry = Rm[WIDTH-1], cnt = 0.
- Count saturation:
  - LSL/LSR: cnt = min(a, WIDTH+1).
  - ASR: cnt = min(a, WIDTH).
  - ROR: cnt = a % WIDTH.
- SHIFT, each cycle:
  - k = min(STEP, cnt).
  - Shift val by k per type (LSR zero-fill, ASR sign-fill, ROR wrap).
  - carry = last bit shifted out; cnt -= k.
  - Go to DONE when cnt reaches 0.
- Results these rules guarantee:
  - LSL/LSR by exactly WIDTH: result 0, carry = Rm[0] (LSL) or Rm[WIDTH-1] (LSR).
  - LSL/LSR by more than WIDTH: result 0, carry 0.
  - ASR by WIDTH or more: all bits = Rm[WIDTH-1], carry = Rm[WIDTH-1].
- Latency (accept edge to out_valid high) = 1 + ceil(cnt/STEP) cycles.
- DONE:
  - val2_out and carry_out are held stable while out_ready=0.
  - On out_ready=1, go to IDLE. out_valid falls at the next edge.
  - No new accept in DONE; minimum issue interval is latency + 1 cycles.
- Outputs are registered. val2_out/carry_out keep their last value in IDLE and SHIFT.

Test Plan:
- Immediate rotate: WIDTH=32, immd=1, shift_operand=0x2FF -> val2_out=0xF000000F, carry_out=1, out_valid 1 cycle after accept.
- LSL #1: Rm=0x80000001, shift_operand=0x080, STEP=1 -> val2_out=0x00000002, carry_out=1, latency 2.
- Register LSR by 32: Rs=0x20, Rm=0x80000000, shift_operand=0x030 -> val2_out=0, carry_out=1. Latency 33 at STEP=1, 5 at STEP=8. Repeat with Rs=0x21 -> val2_out=0, carry_out=0.
- RRX: carry_in=1, Rm=0x00000003, shift_operand=0x060 -> val2_out=0x80000001, carry_out=1, latency 1. Register ROR with Rs=0x40, Rm=0x80000000 -> val2_out=Rm, carry_out=1.
- Memory: is_mem_command=1, immd=1, shift_operand=0xABC, carry_in=0 -> val2_out=0x00000ABC, carry_out=0.
- Handshake/reset:
  - Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored.
  - Drop rst_n during SHIFT -> out_valid=0 and in_ready=1 immediately; no result after release.

Source files
------------

// File: rtl/val2_generator_seq.sv
// Operand-2 generator for the EXE stage: immediate rotate, memory offset and
// immediate/register-amount shifts done iteratively, STEP bits per cycle.
module val2_generator_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Rm,
    input  logic [WIDTH-1:0] Rs,
    input  logic [11:0]      shift_operand,
    input  logic             immd,
    input  logic             is_mem_command,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val2_out,
    output logic             carry_out
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] StepC   = CW'(STEP);
    localparam logic [7:0]    MaxLs   = 8'(WIDTH + 1);
    localparam logic [7:0]    MaxAsr  = 8'(WIDTH);
    localparam logic [7:0]    RorMask = 8'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [1:0]       type_q, type_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] val2_q, val2_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] ld_val, imm_ext;
    logic             ld_carry;
    logic [CW-1:0]    ld_cnt;
    logic [7:0]       amt, ror_amt;
    logic [31:0]      rot;

    logic             unused_rs;
    assign unused_rs = ^Rs[WIDTH-1:8];

    // Load-cycle decode: everything with a zero remaining count is resolved here.
    always_comb begin
        ld_val   = Rm;
        ld_carry = carry_in;
        ld_cnt   = '0;
        imm_ext  = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
        rot      = 32'({shift_operand[11:8], 1'b0});
        amt      = shift_operand[4] ? Rs[7:0] : {3'b000, shift_operand[11:7]};
        ror_amt  = amt & RorMask;
        // Immediate LSR #0 / ASR #0 stand for a shift of 32.
        if (!shift_operand[4] && amt == 8'd0 &&
            (shift_operand[6:5] == 2'b01 || shift_operand[6:5] == 2'b10)) begin
            amt = 8'd32;
        end
        if (is_mem_command) begin
            ld_val = {{(WIDTH-12){1'b0}}, shift_operand};
        end else if (immd) begin
            ld_val   = (imm_ext >> rot) | (imm_ext << (WIDTH - rot));
            ld_carry = (shift_operand[11:8] == 4'd0) ? carry_in : ld_val[WIDTH-1];
        end else if (!shift_operand[4] && shift_operand[6:5] == 2'b11 && amt == 8'd0) begin
            ld_val   = {carry_in, Rm[WIDTH-1:1]};
            ld_carry = Rm[0];
        end else if (amt != 8'd0) begin
            case (shift_operand[6:5])
                2'b00, 2'b01: ld_cnt = CW'((amt > MaxLs) ? MaxLs : amt);
                2'b10:        ld_cnt = CW'((amt > MaxAsr) ? MaxAsr : amt);
                default: begin
                    ld_cnt = CW'(ror_amt);
                    if (ror_amt == 8'd0) ld_carry = Rm[WIDTH-1];
                end
            endcase
        end
    end

    logic [CW-1:0]    step_k;
    logic [31:0]      k32;
    logic [WIDTH-1:0] sh_val, lsl_m1, lsr_m1;
    logic             sh_carry;

    // One SHIFT step; the carry is the last bit to leave, found by shifting k-1.
    always_comb begin
        step_k   = (cnt_q < StepC) ? cnt_q : StepC;
        k32      = 32'(step_k);
        lsl_m1   = val_q << (step_k - CW'(1));
        lsr_m1   = val_q >> (step_k - CW'(1));
        sh_val   = val_q;
        sh_carry = 1'b0;
        case (type_q)
            2'b00: begin
                sh_val   = val_q << step_k;
                sh_carry = lsl_m1[WIDTH-1];
            end
            2'b01: begin
                sh_val   = val_q >> step_k;
                sh_carry = lsr_m1[0];
            end
            2'b10: begin
                sh_val   = $signed(val_q) >>> step_k;
                sh_carry = lsr_m1[0];
            end
            default: begin
                sh_val   = (val_q >> step_k) | (val_q << (WIDTH - k32));
                sh_carry = lsr_m1[0];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        val2_d  = val2_q;
        cout_d  = cout_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    val_d  = ld_val;
                    type_d = shift_operand[6:5];
                    cnt_d  = ld_cnt;
                    if (ld_cnt == '0) begin
                        state_d = StDone;
                        val2_d  = ld_val;
                        cout_d  = ld_carry;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                val_d = sh_val;
                cnt_d = cnt_q - step_k;
                if (cnt_q == step_k) begin
                    state_d = StDone;
                    val2_d  = sh_val;
                    cout_d  = sh_carry;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            val_q   <= '0;
            type_q  <= 2'b00;
            cnt_q   <= '0;
            val2_q  <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            val2_q  <= val2_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign val2_out  = val2_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_val2_generator_seq.sv
// Bench for val2_generator_seq: STEP=1 and STEP=8 instances share stimulus and
// are checked against fixed vectors, corner sequences and an ARM-rule model.
module tb_val2_generator_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] Rm = '0;
    logic [31:0] Rs = '0;
    logic [11:0] so = '0;
    logic        immd = 1'b0;
    logic        mem = 1'b0;
    logic        cin = 1'b0;

    logic        rdy1, vld1, co1, rdy8, vld8, co8;
    logic [31:0] v1, v8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    val2_generator_seq #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .Rm(Rm), .Rs(Rs),
        .shift_operand(so), .immd(immd), .is_mem_command(mem), .carry_in(cin),
        .out_valid(vld1), .out_ready(out_ready), .val2_out(v1), .carry_out(co1)
    );

    val2_generator_seq #(.WIDTH(32), .STEP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .Rm(Rm), .Rs(Rs),
        .shift_operand(so), .immd(immd), .is_mem_command(mem), .carry_in(cin),
        .out_valid(vld8), .out_ready(out_ready), .val2_out(v8), .carry_out(co8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
        if (r == 0) return x;
        return (x >> r) | (x << (32 - r));
    endfunction

    // ARM operand-2 rules written piecewise; n is the count of bits to shift.
    task automatic model(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] s,
                         input logic im, input logic mc, input logic ci,
                         output logic [31:0] v, output logic c, output int n);
        int a;
        int t;
        t = int'(s[6:5]);
        n = 0;
        v = rm;
        c = ci;
        a = s[4] ? int'(rs[7:0]) : int'(s[11:7]);
        if (mc) begin
            v = {20'h0, s};
        end else if (im) begin
            v = ror32({24'h0, s[7:0]}, 2 * int'(s[11:8]));
            c = (s[11:8] == 4'd0) ? ci : v[31];
        end else begin
            if (!s[4] && a == 0 && (t == 1 || t == 2)) a = 32;
            if (!s[4] && a == 0 && t == 3) begin
                v = {ci, rm[31:1]};
                c = rm[0];
            end else if (a != 0) begin
                case (t)
                    0: begin
                        n = (a > 33) ? 33 : a;
                        if (a < 32) begin v = rm << a; c = rm[32 - a]; end
                        else if (a == 32) begin v = 0; c = rm[0]; end
                        else begin v = 0; c = 1'b0; end
                    end
                    1: begin
                        n = (a > 33) ? 33 : a;
                        if (a < 32) begin v = rm >> a; c = rm[a - 1]; end
                        else if (a == 32) begin v = 0; c = rm[31]; end
                        else begin v = 0; c = 1'b0; end
                    end
                    2: begin
                        n = (a > 32) ? 32 : a;
                        if (a < 32) begin v = $signed(rm) >>> a; c = rm[a - 1]; end
                        else begin v = {32{rm[31]}}; c = rm[31]; end
                    end
                    default: begin
                        n = a % 32;
                        if (n == 0) c = rm[31];
                        else begin v = ror32(rm, n); c = v[31]; end
                    end
                endcase
            end
        end
    endtask

    task automatic run_txn(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] s,
                           input logic im, input logic mc, input logic ci,
                           input logic [31:0] ev, input logic ec, input int el1, input int el8,
                           input string tag);
        int e;
        int lat1;
        int lat8;
        logic [31:0] r1, r8;
        logic c1, c8;
        lat1 = -1; lat8 = -1; r1 = '0; r8 = '0; c1 = 1'b0; c8 = 1'b0;
        e = 0;
        @(negedge clk);
        while (!(rdy1 && rdy8) && e < 200) begin
            @(negedge clk);
            e++;
        end
        check({tag, "_idle"}, {63'b0, rdy1 && rdy8}, 64'd1);
        Rm = rm; Rs = rs; so = s; immd = im; mem = mc; cin = ci;
        in_valid = 1'b1;
        for (int k = 1; k <= 100 && (lat1 < 0 || lat8 < 0); k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (vld1 && lat1 < 0) begin lat1 = k; r1 = v1; c1 = co1; end
            if (vld8 && lat8 < 0) begin lat8 = k; r8 = v8; c8 = co8; end
        end
        check({tag, "_val_s1"}, {32'b0, r1}, {32'b0, ev});
        check({tag, "_carry_s1"}, {63'b0, c1}, {63'b0, ec});
        check({tag, "_lat_s1"}, 64'(lat1), 64'(el1));
        check({tag, "_val_s8"}, {32'b0, r8}, {32'b0, ev});
        check({tag, "_carry_s8"}, {63'b0, c8}, {63'b0, ec});
        check({tag, "_lat_s8"}, 64'(lat8), 64'(el8));
    endtask

    typedef struct {
        logic [31:0] rm;
        logic [31:0] rs;
        logic [11:0] so;
        logic        im;
        logic        mc;
        logic        ci;
        logic [31:0] ev;
        logic        ec;
        int          l1;
        int          l8;
        string       name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] mv;
        logic mc_exp;
        int mn;
        logic [31:0] rrm, rrs;
        logic [11:0] rso;
        logic rim, rmc, rci;
        int cnt;

        vecs[0]  = '{32'h0, 32'h0, 12'h2FF, 1'b1, 1'b0, 1'b0, 32'hF000000F, 1'b1, 1, 1, "imm_rot"};
        vecs[1]  = '{32'h80000001, 32'h0, 12'h080, 1'b0, 1'b0, 1'b0, 32'h2, 1'b1, 2, 2, "lsl1"};
        vecs[2]  = '{32'h80000000, 32'h20, 12'h030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 33, 5, "rlsr32"};
        vecs[3]  = '{32'h80000000, 32'h21, 12'h030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 34, 6, "rlsr33"};
        vecs[4]  = '{32'h3, 32'h0, 12'h060, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1, 1, 1, "rrx"};
        vecs[5]  = '{32'h80000000, 32'h40, 12'h070, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b1, 1, 1,
                     "rror64"};
        vecs[6]  = '{32'h0, 32'h0, 12'hABC, 1'b1, 1'b1, 1'b0, 32'hABC, 1'b0, 1, 1, "mem"};
        vecs[7]  = '{32'h80000000, 32'h0, 12'h040, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 33, 5,
                     "asr0"};
        vecs[8]  = '{32'h7FFFFFFF, 32'hC8, 12'h050, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 33, 5, "rasr200"};
        vecs[9]  = '{32'h1, 32'h20, 12'h010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 33, 5, "rlsl32"};
        vecs[10] = '{32'h80000000, 32'h0, 12'h020, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 33, 5, "lsr0"};
        vecs[11] = '{32'h12345678, 32'h100, 12'h010, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1, 1,
                     "rzero"};
        vecs[12] = '{32'hF, 32'h0, 12'h260, 1'b0, 1'b0, 1'b0, 32'hF0000000, 1'b1, 5, 2, "ror4"};
        vecs[13] = '{32'h0, 32'h0, 12'h0AB, 1'b1, 1'b0, 1'b1, 32'hAB, 1'b1, 1, 1, "imm_rot0"};

        repeat (2) @(negedge clk);
        check("rst_in_ready", {63'b0, rdy1}, 64'd1);
        check("rst_out_valid", {63'b0, vld1}, 64'd0);
        check("rst_val2", {32'b0, v1}, 64'd0);
        check("rst_carry", {63'b0, co1}, 64'd0);
        check("rst_in_ready_s8", {63'b0, rdy8}, 64'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_txn(vecs[i].rm, vecs[i].rs, vecs[i].so, vecs[i].im, vecs[i].mc, vecs[i].ci,
                    vecs[i].ev, vecs[i].ec, vecs[i].l1, vecs[i].l8, vecs[i].name);
        end

        // DONE held with out_ready low; a competing request must be ignored.
        @(negedge clk);
        out_ready = 1'b0;
        Rm = '0; Rs = '0; so = 12'h2FF; immd = 1'b1; mem = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("hold_valid0", {63'b0, vld1}, 64'd1);
        so = 12'h0AB; cin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", {62'b0, vld1, vld8}, 64'd3);
            check("hold_ready", {62'b0, rdy1, rdy8}, 64'd0);
            check("hold_val", {v1, v8}, {32'hF000000F, 32'hF000000F});
            check("hold_carry", {62'b0, co1, co8}, 64'd3);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("release_valid", {62'b0, vld1, vld8}, 64'd0);
        check("release_ready", {62'b0, rdy1, rdy8}, 64'd3);
        check("release_keep", {32'b0, v1}, {32'b0, 32'hF000000F});

        // Reset in the middle of a long shift aborts it.
        Rm = 32'h80000000; Rs = 32'h20; so = 12'h030; immd = 1'b0; mem = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", {60'b0, rdy1, rdy8, vld1, vld8}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {62'b0, rdy1, rdy8}, 64'd3);
        check("mid_rst_valid", {62'b0, vld1, vld8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (vld1 || vld8) cnt++;
        end
        check("mid_rst_no_result", 64'(cnt), 64'd0);
        check("mid_rst_val2", {v1, v8}, 64'd0);

        for (int i = 0; i < 250; i++) begin
            rrm = $urandom;
            case ($urandom_range(0, 2))
                0: rrs = $urandom;
                1: rrs = $urandom_range(0, 40);
                default: rrs = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 70));
            endcase
            rso = 12'($urandom_range(0, 4095));
            rim = ($urandom_range(0, 3) == 0);
            rmc = ($urandom_range(0, 7) == 0);
            rci = 1'($urandom_range(0, 1));
            model(rrm, rrs, rso, rim, rmc, rci, mv, mc_exp, mn);
            run_txn(rrm, rrs, rso, rim, rmc, rci, mv, mc_exp, 1 + mn, 1 + (mn + 7) / 8,
                    $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
